shadow_ram_port_mux: RTL and testbench
======================================

SHADOW_RAM_PORT_MUX -- requirements
Module: shadow_ram_port_mux

Interface
REQ-001 SHALL have parameter num_words, default 512, giving the RAM depth in 32-bit words; localparam num_addr_bits = $clog2(num_words).
REQ-002 SHALL have parameter ram_read_latency, default 2, giving the RAM read latency in cycles (legal 1..4).
REQ-003 SHALL have parameter host_write_enable, default 0; 1 permits host writes to the RAM.
REQ-004 Ports, in order (name  direction  width  meaning):
- clk  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- copy_data_i  in  32  copier write data.
- copy_addr_i  in  num_addr_bits  copier write word address.
- copy_be_i  in  4  copier byte enables.
- copy_we_i  in  1  copier write strobe.
- copy_complete_i  in  1  copier done flag.
- host_addr_i  in  num_addr_bits  host word address.
- host_read_i  in  1  host read request.
- host_write_i  in  1  host write request.
- host_wdata_i  in  32  host write data.
- host_be_i  in  4  host byte enables.
- host_wait_req_o  out  1  host stall.
- host_rdata_o  out  32  host read data.
- host_valid_o  out  1  host read data valid.
- ram_addr_o  out  num_addr_bits  RAM address.
- ram_data_o  out  32  RAM write data.
- ram_be_o  out  4  RAM byte enables.
- ram_we_o  out  1  RAM write enable.
- ram_q_i  in  32  RAM read data.
- ready_o  out  1  host owns the RAM.
- checksum_o  out  32  running sum of copied words.
- protect_err_o  out  1  sticky flag for a dropped host write.

Function
REQ-005 SHALL implement a one-hot FSM with three states: COPY (reset state), SWITCH, READY.
REQ-006 COPY: ram_* outputs SHALL be driven combinationally from copy_*; host_wait_req_o=1; host requests SHALL NOT be accepted.
REQ-007 COPY->SWITCH SHALL occur on the first clk edge with copy_complete_i=1; a copy_we_i in that same cycle SHALL still be written.
REQ-008 SWITCH SHALL last exactly one cycle with ram_we_o=0 and host_wait_req_o=1, then go to READY.
REQ-009 READY SHALL be terminal until reset; copy_complete_i falling and copy_we_i SHALL be ignored there.
REQ-010 In READY, host_wait_req_o=0 and ready_o=1; ram_addr_o=host_addr_i.
REQ-011 In READY, a host_read_i SHALL be accepted every cycle (fully pipelined).
REQ-012 Host read data SHALL be ram_q_i sampled ram_read_latency cycles after acceptance, registered into host_rdata_o.
- host_valid_o SHALL pulse for one cycle per accepted read, in order.
- First-word latency SHALL be ram_read_latency+1 cycles.
REQ-013 Host write with host_write_enable=1: ram_we_o=1, ram_data_o=host_wdata_i, ram_be_o=host_be_i in the same cycle.
REQ-014 Host write with host_write_enable=0: the write SHALL be accepted (no stall), ram_we_o=0, and protect_err_o set to 1 (sticky).
REQ-015 host_read_i and host_write_i asserted together SHALL be treated as a write only; no host_valid_o results.
REQ-016 checksum_o SHALL add (copy_data_i AND byte mask of copy_be_i) modulo 2^32 on each copy_we_i accepted in COPY; it wraps silently and freezes after COPY.

Reset
REQ-017 On reset_n=0 the block SHALL asynchronously enter COPY and hold outputs as follows.
- host_wait_req_o=1.
- host_valid_o=0, host_rdata_o=0.
- ready_o=0, checksum_o=0, protect_err_o=0.
- The read-valid pipeline SHALL be cleared.
REQ-018 Reset during READY with reads in flight SHALL discard them; no host_valid_o SHALL follow the release of reset.
REQ-019 Release of reset SHALL be synchronized to clk with a two-flop synchronizer whose output deasserts synchronously.

Structure
REQ-020 The shared package SHALL hold the one-hot state constants (COPY='h1, SWITCH='h2, READY='h4) and the 32-bit data width constant.
REQ-021 The read-valid/data delay line SHALL be one sub-module, shadow_rd_pipe, parameterized by ram_read_latency.

Verification
REQ-022 Reset, 3 copy writes 0x11111111/0x22222222/0x33333333 with be=0xF, then complete -> checksum_o=0x66666666; ready_o=1 exactly 2 cycles after complete is sampled.
REQ-023 Copy write 0xFFFFFFFF with be=0x1 -> checksum_o increments by 0x000000FF.
REQ-024 Host read of addr 5 held during COPY -> host_wait_req_o=1 and no RAM access; the read is accepted in READY and host_valid_o rises 3 cycles later (latency 2) with the RAM word.
REQ-025 4 back-to-back READY reads of addrs 0..3 -> 4 consecutive host_valid_o cycles with data in order.
REQ-026 Host write of 0xDEADBEEF with host_write_enable=0 -> ram_we_o stays 0 and protect_err_o=1 until reset; with host_write_enable=1 -> ram_we_o=1 in the same cycle.
REQ-027 Assert reset_n=0 one cycle after 2 reads are issued in READY -> no host_valid_o after release; FSM in COPY; checksum_o=0.

Source files
------------

// File: rtl/shadow_ram_port_mux_pkg.sv
// Shared definitions for the shadow RAM port mux.
// Holds the data width, the one-hot FSM encoding and the byte-enable mask helper.
package shadow_ram_port_mux_pkg;

  localparam int unsigned data_w = 32;

  // One-hot states: copier owns the RAM, one idle handover cycle, host owns the RAM.
  typedef enum logic [2:0] {
    COPY   = 3'h1,
    SWITCH = 3'h2,
    READY  = 3'h4
  } state_e;

  // Expand four byte enables into a 32-bit lane mask.
  function automatic logic [data_w-1:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/shadow_ram_port_mux_rd_pipe.sv
// Read-valid delay line for host reads.
// Ports: clk, rst_n (internal synchronized reset), rd_accept (read accepted this
// cycle), ram_q (RAM read data), rd_valid / rd_data (registered host read result).
// A read accepted at edge N is captured from ram_q at edge N+ram_read_latency.
module shadow_rd_pipe
  import shadow_ram_port_mux_pkg::*;
#(
  parameter int unsigned ram_read_latency = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_accept,
  input  logic [data_w-1:0] ram_q,
  output logic              rd_valid,
  output logic [data_w-1:0] rd_data
);

  localparam int unsigned lat_w = ram_read_latency;
  localparam int unsigned last  = ram_read_latency - 1;

  logic [lat_w-1:0] vld_q;

  // Shift acceptance markers until the RAM data they belong to is on ram_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      vld_q    <= (vld_q << 1) | lat_w'(rd_accept);
      rd_valid <= vld_q[last];
      if (vld_q[last]) begin
        rd_data <= ram_q;
      end
    end
  end

endmodule

// File: rtl/shadow_ram_port_mux.sv
// Shadow RAM port mux: the copier fills the RAM first, then ownership passes to
// the host for pipelined reads and (optionally) writes.
// Ports: clk, reset_n (async active-low); copy_* copier write port;
// host_* host request/response port; ram_* RAM port; ready_o host owns RAM;
// checksum_o sum of masked copier words; protect_err_o sticky blocked-write flag.
module shadow_ram_port_mux
  import shadow_ram_port_mux_pkg::*;
#(
  parameter  int unsigned num_words         = 512,
  parameter  int unsigned ram_read_latency  = 2,
  parameter  int unsigned host_write_enable = 0,
  localparam int unsigned num_addr_bits     = $clog2(num_words)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [data_w-1:0]        copy_data_i,
  input  logic [num_addr_bits-1:0] copy_addr_i,
  input  logic [3:0]               copy_be_i,
  input  logic                     copy_we_i,
  input  logic                     copy_complete_i,
  input  logic [num_addr_bits-1:0] host_addr_i,
  input  logic                     host_read_i,
  input  logic                     host_write_i,
  input  logic [data_w-1:0]        host_wdata_i,
  input  logic [3:0]               host_be_i,
  output logic                     host_wait_req_o,
  output logic [data_w-1:0]        host_rdata_o,
  output logic                     host_valid_o,
  output logic [num_addr_bits-1:0] ram_addr_o,
  output logic [data_w-1:0]        ram_data_o,
  output logic [3:0]               ram_be_o,
  output logic                     ram_we_o,
  input  logic [data_w-1:0]        ram_q_i,
  output logic                     ready_o,
  output logic [data_w-1:0]        checksum_o,
  output logic                     protect_err_o
);

  localparam bit hwe_en = (host_write_enable != 0);

  logic [1:0]  rst_sync_q;
  logic        rst_n;
  state_e      state_q;
  state_e      state_d;
  logic        rd_accept;
  logic        wr_blocked;
  logic [data_w-1:0] checksum_q;
  logic        protect_err_q;

  // Reset asserts immediately, releases two clk edges after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COPY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and RAM port steering.
  always_comb begin
    state_d    = state_q;
    ram_addr_o = host_addr_i;
    ram_data_o = host_wdata_i;
    ram_be_o   = host_be_i;
    ram_we_o   = 1'b0;
    rd_accept  = 1'b0;
    wr_blocked = 1'b0;
    case (state_q)
      COPY: begin
        ram_addr_o = copy_addr_i;
        ram_data_o = copy_data_i;
        ram_be_o   = copy_be_i;
        ram_we_o   = copy_we_i;
        if (copy_complete_i) begin
          state_d = SWITCH;
        end
      end
      SWITCH: begin
        state_d = READY;
      end
      READY: begin
        // A simultaneous read and write is a write only.
        rd_accept  = host_read_i & ~host_write_i;
        ram_we_o   = host_write_i & hwe_en;
        wr_blocked = host_write_i & ~hwe_en;
      end
      default: begin
        state_d = COPY;
      end
    endcase
  end

  // Copy checksum (frozen outside COPY) and sticky write-protect flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q    <= '0;
      protect_err_q <= 1'b0;
    end else begin
      if (state_q == COPY && copy_we_i) begin
        checksum_q <= checksum_q + (copy_data_i & be_mask(copy_be_i));
      end
      if (wr_blocked) begin
        protect_err_q <= 1'b1;
      end
    end
  end

  shadow_rd_pipe #(
    .ram_read_latency(ram_read_latency)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_accept(rd_accept),
    .ram_q    (ram_q_i),
    .rd_valid (host_valid_o),
    .rd_data  (host_rdata_o)
  );

  assign host_wait_req_o = (state_q != READY);
  assign ready_o         = (state_q == READY);
  assign checksum_o      = checksum_q;
  assign protect_err_o   = protect_err_q;

endmodule

// File: tb/tb_shadow_ram_port_mux.sv
// Self-checking bench for shadow_ram_port_mux: a write-protected instance with a
// behavioural RAM behind it, plus a write-enabled instance sharing the stimulus.
module tb_shadow_ram_port_mux;

  localparam int unsigned NW  = 512;
  localparam int unsigned AW  = 9;
  localparam int unsigned LAT = 2;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [31:0]   copy_data;
  logic [AW-1:0] copy_addr;
  logic [3:0]    copy_be;
  logic          copy_we;
  logic          copy_complete;
  logic [AW-1:0] host_addr;
  logic          host_read;
  logic          host_write;
  logic [31:0]   host_wdata;
  logic [3:0]    host_be;

  logic          d0_wait, d0_valid, d0_we, d0_ready, d0_perr;
  logic [31:0]   d0_rdata, d0_data, d0_sum, ram_q;
  logic [AW-1:0] d0_addr;
  logic [3:0]    d0_be;

  logic          d1_wait, d1_valid, d1_we, d1_ready, d1_perr;
  logic [31:0]   d1_rdata, d1_data, d1_sum;
  logic [AW-1:0] d1_addr;
  logic [3:0]    d1_be;
  logic [31:0]   zero_q;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  rd_t         rdq[$];
  logic [31:0] exp_mem [16];
  logic [31:0] exp_sum;
  logic        exp_perr;

  logic [31:0] ram [NW];
  logic [31:0] q_pipe [LAT];

  assign zero_q = 32'h0;

  always #5 clk = ~clk;

  shadow_ram_port_mux #(
    .num_words(NW), .ram_read_latency(LAT), .host_write_enable(0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n),
    .copy_data_i(copy_data), .copy_addr_i(copy_addr), .copy_be_i(copy_be),
    .copy_we_i(copy_we), .copy_complete_i(copy_complete),
    .host_addr_i(host_addr), .host_read_i(host_read), .host_write_i(host_write),
    .host_wdata_i(host_wdata), .host_be_i(host_be),
    .host_wait_req_o(d0_wait), .host_rdata_o(d0_rdata), .host_valid_o(d0_valid),
    .ram_addr_o(d0_addr), .ram_data_o(d0_data), .ram_be_o(d0_be), .ram_we_o(d0_we),
    .ram_q_i(ram_q), .ready_o(d0_ready), .checksum_o(d0_sum), .protect_err_o(d0_perr)
  );

  shadow_ram_port_mux #(
    .num_words(NW), .ram_read_latency(LAT), .host_write_enable(1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n),
    .copy_data_i(copy_data), .copy_addr_i(copy_addr), .copy_be_i(copy_be),
    .copy_we_i(copy_we), .copy_complete_i(copy_complete),
    .host_addr_i(host_addr), .host_read_i(host_read), .host_write_i(host_write),
    .host_wdata_i(host_wdata), .host_be_i(host_be),
    .host_wait_req_o(d1_wait), .host_rdata_o(d1_rdata), .host_valid_o(d1_valid),
    .ram_addr_o(d1_addr), .ram_data_o(d1_data), .ram_be_o(d1_be), .ram_we_o(d1_we),
    .ram_q_i(zero_q), .ready_o(d1_ready), .checksum_o(d1_sum), .protect_err_o(d1_perr)
  );

  // Behavioural RAM: registered read with LAT cycles from address to q.
  always @(posedge clk) begin
    if (d0_we) begin
      for (int b = 0; b < 4; b++) begin
        if (d0_be[b]) ram[d0_addr][b*8 +: 8] <= d0_data[b*8 +: 8];
      end
    end
    q_pipe[0] <= ram[d0_addr];
    for (int i = 1; i < LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end

  assign ram_q = q_pipe[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) m = m | (32'hFF << (8 * i));
    end
    return m;
  endfunction

  // Reference update for one accepted copier write.
  task automatic model_copy(input int unsigned a, input logic [31:0] d, input logic [3:0] be);
    exp_sum = exp_sum + (d & bmask(be));
    if (a < 16) exp_mem[a] = (exp_mem[a] & ~bmask(be)) | (d & bmask(be));
  endtask

  // One copier write cycle in COPY, checking the RAM port follows the copier.
  task automatic copy_wr(input int unsigned a, input logic [31:0] d, input logic [3:0] be);
    copy_addr = AW'(a);
    copy_data = d;
    copy_be   = be;
    copy_we   = 1'b1;
    @(negedge clk);
    chk("copy_we", 32'(d0_we), 32'd1);
    chk("copy_addr", 32'(d0_addr), a);
    chk("copy_data", d0_data, d);
    chk("copy_be", 32'(d0_be), 32'(be));
    chk("copy_wait", 32'(d0_wait), 32'd1);
    tick();
    model_copy(a, d, be);
    copy_we = 1'b0;
  endtask

  task automatic push_rd(input int unsigned a);
    rd_t e;
    e.data = exp_mem[a];
    e.due  = cyc + LAT + 1;
    rdq.push_back(e);
  endtask

  // Read-return scoreboard: data, order and latency.
  always @(negedge clk) begin
    rd_t e;
    if (rdq.size() > 0 && rdq[0].due < cyc) begin
      chk("rd_missing", 32'(cyc), 32'(rdq[0].due));
      void'(rdq.pop_front());
    end
    if (d0_valid) begin
      if (rdq.size() == 0) begin
        chk("rd_unexpected", 32'(d0_valid), 32'd0);
      end else begin
        e = rdq.pop_front();
        chk("rd_data", d0_rdata, e.data);
        chk("rd_lat", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    copy_data = '0; copy_addr = '0; copy_be = '0; copy_we = 1'b0; copy_complete = 1'b0;
    host_addr = '0; host_read = 1'b0; host_write = 1'b0; host_wdata = '0; host_be = '0;
    exp_sum = 32'h0;
    exp_perr = 1'b0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;

    repeat (3) tick();
    @(negedge clk);
    chk("rst_wait", 32'(d0_wait), 32'd1);
    chk("rst_valid", 32'(d0_valid), 32'd0);
    chk("rst_rdata", d0_rdata, 32'h0);
    chk("rst_ready", 32'(d0_ready), 32'd0);
    chk("rst_sum", d0_sum, 32'h0);
    chk("rst_perr", 32'(d0_perr), 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();

    // Directed checksum cases.
    copy_wr(0, 32'h11111111, 4'hF);
    copy_wr(1, 32'h22222222, 4'hF);
    copy_wr(2, 32'h33333333, 4'hF);
    @(negedge clk);
    chk("sum_3words", d0_sum, 32'h66666666);
    tick();
    copy_wr(3, 32'hFFFFFFFF, 4'h1);
    @(negedge clk);
    chk("sum_be1", d0_sum, 32'h66666765);
    tick();

    // Fill the readable window, then random partial writes and idle cycles.
    for (int a = 0; a < 16; a++) copy_wr(a, $urandom, 4'hF);
    for (int i = 0; i < 40; i++) begin
      if (i >= 30) begin
        host_addr = AW'(5);
        host_read = 1'b1;
      end
      if ($urandom_range(0, 3) != 0) begin
        copy_wr($urandom_range(0, 15), $urandom, 4'($urandom_range(0, 15)));
      end else begin
        copy_data = $urandom;
        copy_addr = AW'($urandom_range(0, 15));
        @(negedge clk);
        chk("copy_idle_we", 32'(d0_we), 32'd0);
        chk("copy_rd_wait", 32'(d0_wait), 32'd1);
        tick();
      end
    end
    @(negedge clk);
    chk("sum_random", d0_sum, exp_sum);

    // Completion cycle still writes; host read of addr 5 is held throughout.
    tick();
    copy_addr = AW'(6); copy_data = $urandom; copy_be = 4'hF; copy_we = 1'b1;
    copy_complete = 1'b1;
    @(negedge clk);
    chk("cmpl_we", 32'(d0_we), 32'd1);
    chk("cmpl_ready", 32'(d0_ready), 32'd0);
    tick();
    model_copy(6, copy_data, 4'hF);
    copy_complete = 1'b0;
    copy_data = $urandom;
    @(negedge clk);
    chk("sw_ready", 32'(d0_ready), 32'd0);
    chk("sw_wait", 32'(d0_wait), 32'd1);
    chk("sw_we", 32'(d0_we), 32'd0);
    tick();
    @(negedge clk);
    chk("rdy_ready", 32'(d0_ready), 32'd1);
    chk("rdy_wait", 32'(d0_wait), 32'd0);
    chk("rdy_addr", 32'(d0_addr), 32'd5);
    chk("rdy_we_ignored", 32'(d0_we), 32'd0);
    push_rd(5);
    tick();
    host_read = 1'b0;
    copy_we = 1'b0;
    @(negedge clk);
    chk("sum_frozen", d0_sum, exp_sum);
    repeat (LAT + 3) tick();

    // Back-to-back reads of addrs 0..3.
    for (int a = 0; a < 4; a++) begin
      host_addr = AW'(a);
      host_read = 1'b1;
      push_rd(a);
      tick();
    end
    host_read = 1'b0;
    repeat (LAT + 4) tick();

    // Blocked write of 0xDEADBEEF, then random host traffic.
    host_write = 1'b1; host_wdata = 32'hDEADBEEF; host_be = 4'hF; host_addr = AW'(9);
    @(negedge clk);
    chk("dead_we0", 32'(d0_we), 32'd0);
    chk("dead_we1", 32'(d1_we), 32'd1);
    chk("dead_data1", d1_data, 32'hDEADBEEF);
    chk("dead_perr_pre", 32'(d0_perr), 32'd0);
    tick();
    exp_perr = 1'b1;
    for (int i = 0; i < 80; i++) begin
      host_addr  = AW'($urandom_range(0, 15));
      host_read  = 1'($urandom_range(0, 1));
      host_write = ($urandom_range(0, 3) == 0);
      host_wdata = $urandom;
      host_be    = 4'($urandom_range(0, 15));
      if (host_read && !host_write) push_rd(int'(host_addr));
      @(negedge clk);
      chk("hw_we0", 32'(d0_we), 32'd0);
      chk("hw_we1", 32'(d1_we), 32'(host_write));
      if (host_write) begin
        chk("hw_data1", d1_data, host_wdata);
        chk("hw_be1", 32'(d1_be), 32'(host_be));
      end
      chk("hw_addr", 32'(d0_addr), 32'(host_addr));
      chk("perr0", 32'(d0_perr), 32'(exp_perr));
      chk("perr1", 32'(d1_perr), 32'd0);
      tick();
    end
    host_read = 1'b0;
    host_write = 1'b0;
    repeat (LAT + 4) tick();
    chk("rd_pending", 32'(rdq.size()), 32'd0);

    // Reset with two reads in flight.
    host_addr = AW'(1); host_read = 1'b1; push_rd(1); tick();
    host_addr = AW'(2); push_rd(2); tick();
    host_read = 1'b0;
    tick();
    reset_n = 1'b0;
    rdq.delete();
    repeat (2) tick();
    @(negedge clk);
    chk("mid_rst_valid", 32'(d0_valid), 32'd0);
    chk("mid_rst_ready", 32'(d0_ready), 32'd0);
    chk("mid_rst_perr", 32'(d0_perr), 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    copy_addr = AW'(7); copy_data = 32'hA5A5A5A5; copy_be = 4'hF; copy_we = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(d0_ready), 32'd0);
    chk("post_rst_wait", 32'(d0_wait), 32'd1);
    chk("post_rst_sum", d0_sum, 32'h0);
    chk("post_rst_perr", 32'(d0_perr), 32'd0);
    chk("post_rst_copy_we", 32'(d0_we), 32'd1);
    chk("post_rst_copy_addr", 32'(d0_addr), 32'd7);
    tick();
    copy_we = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
